el2_ifu_ic_fill_ctl: RTL and testbench
======================================

// Module: el2_ifu_ic_fill_ctl
// PURPOSE
// - I-cache miss fill engine, on the bus side of el2_ifu_mem_ctl.
// - Takes one miss (line address + critical beat), issues single-beat AXI reads in wrap order (critical beat first).
// - Collects out-of-order responses by RID and streams beats to the cache write port.
// - Forwards the critical beat early; reports done/error and PMU bus events.
// PARAMETERS
// - ICACHE_BEAT_BITS  3   log2 beats per line (8 x 64b = 64B line)
// - BUS_TAG           3   AXI ARID/RID width; must be >= ICACHE_BEAT_BITS
// PORTS
// - clock              in   1   core clock
// - reset              in   1   asynchronous, active-high reset
// - io_ifu_bus_clk_en  in   1   bus clock enable; all AXI handshakes qualify with it
// - io_exu_flush_final in   1   flush: abandon current miss
// - io_miss_req        in   1   start fill (valid only while io_miss_ready)
// - io_miss_addr       in   31  fetch address bits [31:1]
// - io_miss_uncacheable in  1   1 = fetch critical beat only, no cache write
// - io_miss_ready      out  1   engine idle, accepts io_miss_req
// - io_ifu_axi_arvalid out  1   AR valid
// - io_ifu_axi_arready in   1   AR ready
// - io_ifu_axi_arid    out  BUS_TAG  beat index of request
// - io_ifu_axi_araddr  out  32  {miss_addr[30:5], beat, 3'b000}
// - io_ifu_axi_arsize/arlen/arburst out 3/8/2  constants 3'h3 / 8'h0 / 2'h1
// - io_ifu_axi_rvalid, io_ifu_axi_rid, io_ifu_axi_rdata, io_ifu_axi_rresp  in  1/BUS_TAG/64/2  R channel
// - io_ifu_axi_rready  out  1   1 whenever not in reset
// - io_fill_wr_en/_beat/_data/_err out 1/3/64/1  cache write beat (cacheable fills only)
// - io_crit_valid/_data/_err out 1/64/1  critical beat forward, 1-cycle pulse
// - io_fill_done, io_fill_err out 1/1  1-cycle pulse at end of fill; err = any beat RRESP!=0
// - io_pmu_bus_trxn/_busy/_error out 1/1/1  AR accepted / AR stalled / error beat
// BEHAVIOUR
// - Reset: state IDLE, counters 0, all outputs 0 except io_miss_ready=1, io_ifu_axi_rready=1.
// - States: IDLE -> ISSUE on io_miss_req & io_miss_ready; latch addr, crit = miss_addr[4:2], nreq = uncacheable ? 1 : 8.
// - ISSUE: arvalid=1, arid=crit+ar_cnt (mod 8); AR fires on arvalid&arready&bus_clk_en -> ar_cnt++.
// - AXI rule: arvalid, arid, araddr held stable until fire; never retracted, even on flush.
// - ISSUE -> WAIT when ar_cnt reaches nreq; WAIT -> DONE when r_cnt == nreq.
// - DONE: 1 cycle, pulses io_fill_done (io_fill_err = sticky err), then IDLE.
// - Beat accept: rvalid & bus_clk_en -> r_cnt++.
//   - Cacheable, not flushed: drive io_fill_wr_en same cycle with beat=rid[2:0], data=rdata, err=|rresp.
//   - rid == crit and not flushed: pulse io_crit_valid with the same data/err.
// - Flush in ISSUE/WAIT/DONE: go DRAIN; if an AR is pending, it is completed first and counted.
// - DRAIN: stop new ARs, accept responses with no fill/crit outputs; -> IDLE when r_cnt == ar_cnt. No io_fill_done.
// - Flush in IDLE and same-cycle io_miss_req: request dropped, stay IDLE.
// - Flush in DRAIN: no effect.
// - bus_clk_en=0: no AR/R counting; outputs hold.
// - Latency: first arvalid the cycle after accept; crit/fill outputs combinational from accepted R beat.
// - Widths: beat arithmetic modulo 2^ICACHE_BEAT_BITS; counters ICACHE_BEAT_BITS+1 bits, no wrap.
// - PMU: trxn = AR fire; busy = arvalid & ~arready; error = accepted beat with rresp != 0.
// STRUCTURE
// - el2_ifu_fill_pkg: state enum {IDLE, ISSUE, WAIT, DONE, DRAIN}, AXI size/len/burst constants, beat count.
// - Sub-module el2_ifu_fill_beat_tracker: ar_cnt/r_cnt counters, sticky error, done compare.
// - Top level: FSM, AR register slice, output muxing.
// TESTING
// - miss_addr=0x0000_0014 (byte 0x28), cacheable, arready=1:
//   - ARIDs 5,6,7,0,1,2,3,4; araddr 0x28, 0x30, 0x38, 0x00 ...
//   - RID 5 -> crit pulse; 8 fill writes; fill_done 1 cycle after 8th beat.
// - Responses return in reverse order (RID 4..5): each fill_wr_beat == RID; crit pulses only at RID 5; fill_err=0.
// - Uncacheable miss: exactly one AR (arid=crit), no fill_wr_en, crit pulse, fill_done, miss_ready back.
// - arready=0 for 3 cycles then flush: arvalid/araddr stable; AR completes, DRAIN swallows its R; no crit/done; IDLE.
// - RRESP=2 on beat 3: fill_wr_err=1 for that beat only, pmu_bus_error pulse, fill_err=1 with done.
// - bus_clk_en toggling 1/0 every cycle: no handshake counted when 0; 8 beats still filled correctly.
// - Reset asserted mid-WAIT: outputs and counters 0 at once, miss_ready=1.

Source files
------------

// File: rtl/el2_ifu_fill_pkg.sv
// el2_ifu_fill_pkg
//   Shared types and constants for the I-cache miss fill engine:
//   line geometry, AXI request constants and the fill FSM state encoding.
package el2_ifu_fill_pkg;

   localparam int FILL_BEAT_BITS = 3;                    // log2 beats per line
   localparam int FILL_BUS_TAG   = 3;                    // ARID/RID width
   localparam int FILL_NUM_BEATS = 1 << FILL_BEAT_BITS;  // beats per line

   // Every request is a single 64-bit beat with INCR burst type.
   localparam logic [2:0] AXI_SIZE  = 3'h3;
   localparam logic [7:0] AXI_LEN   = 8'h0;
   localparam logic [1:0] AXI_BURST = 2'h1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      DRAIN
   } fill_state_e;

endpackage

// File: rtl/el2_ifu_fill_beat_tracker.sv
// el2_ifu_fill_beat_tracker
//   Counts issued AR requests and accepted R beats for one fill, keeps the
//   sticky error flag and provides the completion compares for the FSM.
// Ports
//   clk_i, rst_i     clock, async active-high reset
//   clr_i            start of a new miss: clear counters and error
//   ar_fire_i        AR handshake this cycle
//   r_acc_i          R beat accepted this cycle
//   r_err_i          accepted beat carries an error for the live fill
//   nreq_i           number of beats requested for this miss
//   ar_beat_o        low bits of the AR count (offset from critical beat)
//   err_o            sticky error
//   ar_all_o         AR count reaches nreq after this cycle
//   r_all_o          R count reaches nreq after this cycle
//   drained_o        every issued AR has had its response
module el2_ifu_fill_beat_tracker #(
   parameter int BEAT_BITS = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 ar_fire_i,
   input  logic                 r_acc_i,
   input  logic                 r_err_i,
   input  logic [BEAT_BITS:0]   nreq_i,
   output logic [BEAT_BITS-1:0] ar_beat_o,
   output logic                 err_o,
   output logic                 ar_all_o,
   output logic                 r_all_o,
   output logic                 drained_o
);

   // One extra bit so a full line (8) is representable without wrapping.
   logic [BEAT_BITS:0] ar_cnt_q, ar_cnt_d, r_cnt_q, r_cnt_d;
   logic               err_q, err_d;

   always_comb begin
      ar_cnt_d = ar_cnt_q;
      r_cnt_d  = r_cnt_q;
      err_d    = err_q;
      if (clr_i) begin
         ar_cnt_d = '0;
         r_cnt_d  = '0;
         err_d    = 1'b0;
      end else begin
         if (ar_fire_i) ar_cnt_d = ar_cnt_q + 1'b1;
         if (r_acc_i)   r_cnt_d  = r_cnt_q + 1'b1;
         if (r_err_i)   err_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ar_cnt_q <= '0;
         r_cnt_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         ar_cnt_q <= ar_cnt_d;
         r_cnt_q  <= r_cnt_d;
         err_q    <= err_d;
      end
   end

   assign ar_beat_o = ar_cnt_q[BEAT_BITS-1:0];
   assign err_o     = err_q;
   // Compares on next-state counts let the FSM leave ISSUE/WAIT in the
   // same cycle the last handshake completes.
   assign ar_all_o  = (ar_cnt_d == nreq_i);
   assign r_all_o   = (r_cnt_d == nreq_i);
   assign drained_o = (r_cnt_q == ar_cnt_q);

endmodule

// File: rtl/el2_ifu_ic_fill_ctl.sv
// el2_ifu_ic_fill_ctl
//   I-cache miss fill engine. Accepts one miss, issues single-beat AXI reads
//   in wrap order starting at the critical beat, accepts responses in any
//   order by RID, writes beats to the cache, forwards the critical beat and
//   reports done/error and PMU bus events.
// Ports
//   clock, reset             core clock, async active-high reset
//   io_ifu_bus_clk_en        qualifies every AXI handshake
//   io_exu_flush_final       abandon the current miss
//   io_miss_*                miss request (addr = fetch address [31:1])
//   io_ifu_axi_ar*/r*        AXI read address / read data channels
//   io_fill_wr_*             cache write beat (cacheable fills only)
//   io_crit_*                critical beat forward, 1-cycle pulse
//   io_fill_done/_err        end-of-fill pulse and sticky error
//   io_pmu_bus_*             AR accepted / AR stalled / error beat
module el2_ifu_ic_fill_ctl
   import el2_ifu_fill_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_ifu_bus_clk_en,
   input  logic                      io_exu_flush_final,
   input  logic                      io_miss_req,
   input  logic [30:0]               io_miss_addr,
   input  logic                      io_miss_uncacheable,
   output logic                      io_miss_ready,
   output logic                      io_ifu_axi_arvalid,
   input  logic                      io_ifu_axi_arready,
   output logic [FILL_BUS_TAG-1:0]   io_ifu_axi_arid,
   output logic [31:0]               io_ifu_axi_araddr,
   output logic [2:0]                io_ifu_axi_arsize,
   output logic [7:0]                io_ifu_axi_arlen,
   output logic [1:0]                io_ifu_axi_arburst,
   input  logic                      io_ifu_axi_rvalid,
   input  logic [FILL_BUS_TAG-1:0]   io_ifu_axi_rid,
   input  logic [63:0]               io_ifu_axi_rdata,
   input  logic [1:0]                io_ifu_axi_rresp,
   output logic                      io_ifu_axi_rready,
   output logic                      io_fill_wr_en,
   output logic [FILL_BEAT_BITS-1:0] io_fill_wr_beat,
   output logic [63:0]               io_fill_wr_data,
   output logic                      io_fill_wr_err,
   output logic                      io_crit_valid,
   output logic [63:0]               io_crit_data,
   output logic                      io_crit_err,
   output logic                      io_fill_done,
   output logic                      io_fill_err,
   output logic                      io_pmu_bus_trxn,
   output logic                      io_pmu_bus_busy,
   output logic                      io_pmu_bus_error
);

   localparam int BB = FILL_BEAT_BITS;

   fill_state_e         state_q, state_d;
   logic [30-(BB+2):0]  line_q;        // line address, fetch addr [31:BB+3]
   logic [BB-1:0]       crit_q;
   logic                uc_q;
   logic [BB:0]         nreq_q;
   logic                drain_ar_q, drain_ar_d;  // AR still owed after flush

   logic          start, ar_fire, r_acc, live, r_bad, err_q;
   logic          ar_all, r_all, drained;
   logic [BB-1:0] ar_idx, ar_beat, r_beat;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^io_miss_addr[1:0];

   // ---------------- AR channel ----------------
   // arid/araddr derive only from registered state that changes on fire,
   // so they stay stable while arvalid waits for arready.
   assign ar_beat            = crit_q + ar_idx;
   assign io_ifu_axi_arvalid = (state_q == ISSUE) | ((state_q == DRAIN) & drain_ar_q);
   assign io_ifu_axi_arid    = FILL_BUS_TAG'(ar_beat);
   assign io_ifu_axi_araddr  = {line_q, ar_beat, 3'b000};
   assign io_ifu_axi_arsize  = AXI_SIZE;
   assign io_ifu_axi_arlen   = AXI_LEN;
   assign io_ifu_axi_arburst = AXI_BURST;
   assign ar_fire            = io_ifu_axi_arvalid & io_ifu_axi_arready & io_ifu_bus_clk_en;

   // ---------------- R channel ----------------
   assign io_ifu_axi_rready = ~reset;
   assign r_acc  = io_ifu_axi_rvalid & io_ifu_axi_rready & io_ifu_bus_clk_en & (state_q != IDLE);
   assign r_beat = io_ifu_axi_rid[BB-1:0];
   assign r_bad  = |io_ifu_axi_rresp;
   // Beats only reach the cache/fetch while the fill is still wanted.
   assign live   = ((state_q == ISSUE) | (state_q == WAIT)) & ~io_exu_flush_final;

   assign io_fill_wr_en   = r_acc & live & ~uc_q;
   assign io_fill_wr_beat = io_fill_wr_en ? r_beat : '0;
   assign io_fill_wr_data = io_fill_wr_en ? io_ifu_axi_rdata : '0;
   assign io_fill_wr_err  = io_fill_wr_en & r_bad;

   assign io_crit_valid = r_acc & live & (r_beat == crit_q);
   assign io_crit_data  = io_crit_valid ? io_ifu_axi_rdata : '0;
   assign io_crit_err   = io_crit_valid & r_bad;

   assign io_miss_ready = (state_q == IDLE);
   assign io_fill_done  = (state_q == DONE) & ~io_exu_flush_final;
   assign io_fill_err   = io_fill_done & err_q;

   assign io_pmu_bus_trxn  = ar_fire;
   assign io_pmu_bus_busy  = io_ifu_axi_arvalid & ~io_ifu_axi_arready;
   assign io_pmu_bus_error = r_acc & r_bad;

   el2_ifu_fill_beat_tracker #(.BEAT_BITS(BB)) u_trk (
      .clk_i     (clock),
      .rst_i     (reset),
      .clr_i     (start),
      .ar_fire_i (ar_fire),
      .r_acc_i   (r_acc),
      .r_err_i   (r_acc & live & r_bad),
      .nreq_i    (nreq_q),
      .ar_beat_o (ar_idx),
      .err_o     (err_q),
      .ar_all_o  (ar_all),
      .r_all_o   (r_all),
      .drained_o (drained)
   );

   // ---------------- FSM ----------------
   always_comb begin
      state_d    = state_q;
      drain_ar_d = drain_ar_q;
      start      = 1'b0;
      case (state_q)
         IDLE: begin
            if (io_miss_req & ~io_exu_flush_final) begin
               state_d = ISSUE;
               start   = 1'b1;
            end
         end
         ISSUE: begin
            if (io_exu_flush_final) begin
               state_d    = DRAIN;
               // arvalid is already up; it must stay up until it fires.
               drain_ar_d = ~ar_fire;
            end else if (ar_all) begin
               state_d = r_all ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (io_exu_flush_final) state_d = DRAIN;
            else if (r_all)         state_d = DONE;
         end
         DONE: begin
            state_d = io_exu_flush_final ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (ar_fire) drain_ar_d = 1'b0;
            if (~drain_ar_q & drained) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         drain_ar_q <= 1'b0;
         line_q     <= '0;
         crit_q     <= '0;
         uc_q       <= 1'b0;
         nreq_q     <= '0;
      end else begin
         state_q    <= state_d;
         drain_ar_q <= drain_ar_d;
         if (start) begin
            line_q <= io_miss_addr[30:BB+2];
            crit_q <= io_miss_addr[BB+1:2];
            uc_q   <= io_miss_uncacheable;
            nreq_q <= io_miss_uncacheable ? (BB+1)'(1) : (BB+1)'(FILL_NUM_BEATS);
         end
      end
   end

endmodule

// File: tb/tb_el2_ifu_ic_fill_ctl.sv
// Directed bench for el2_ifu_ic_fill_ctl: wrap-order issue, in-order and
// reverse-order responses, uncacheable miss, AR stall with flush/drain,
// error response with bus clock enable toggling, reset mid-fill.
module tb_el2_ifu_ic_fill_ctl;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_ifu_bus_clk_en;
   logic        io_exu_flush_final;
   logic        io_miss_req;
   logic [30:0] io_miss_addr;
   logic        io_miss_uncacheable;
   logic        io_miss_ready;
   logic        io_ifu_axi_arvalid;
   logic        io_ifu_axi_arready;
   logic [2:0]  io_ifu_axi_arid;
   logic [31:0] io_ifu_axi_araddr;
   logic [2:0]  io_ifu_axi_arsize;
   logic [7:0]  io_ifu_axi_arlen;
   logic [1:0]  io_ifu_axi_arburst;
   logic        io_ifu_axi_rvalid;
   logic [2:0]  io_ifu_axi_rid;
   logic [63:0] io_ifu_axi_rdata;
   logic [1:0]  io_ifu_axi_rresp;
   logic        io_ifu_axi_rready;
   logic        io_fill_wr_en;
   logic [2:0]  io_fill_wr_beat;
   logic [63:0] io_fill_wr_data;
   logic        io_fill_wr_err;
   logic        io_crit_valid;
   logic [63:0] io_crit_data;
   logic        io_crit_err;
   logic        io_fill_done;
   logic        io_fill_err;
   logic        io_pmu_bus_trxn;
   logic        io_pmu_bus_busy;
   logic        io_pmu_bus_error;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   el2_ifu_ic_fill_ctl dut (
      .clock(clock), .reset(reset),
      .io_ifu_bus_clk_en(io_ifu_bus_clk_en), .io_exu_flush_final(io_exu_flush_final),
      .io_miss_req(io_miss_req), .io_miss_addr(io_miss_addr),
      .io_miss_uncacheable(io_miss_uncacheable), .io_miss_ready(io_miss_ready),
      .io_ifu_axi_arvalid(io_ifu_axi_arvalid), .io_ifu_axi_arready(io_ifu_axi_arready),
      .io_ifu_axi_arid(io_ifu_axi_arid), .io_ifu_axi_araddr(io_ifu_axi_araddr),
      .io_ifu_axi_arsize(io_ifu_axi_arsize), .io_ifu_axi_arlen(io_ifu_axi_arlen),
      .io_ifu_axi_arburst(io_ifu_axi_arburst),
      .io_ifu_axi_rvalid(io_ifu_axi_rvalid), .io_ifu_axi_rid(io_ifu_axi_rid),
      .io_ifu_axi_rdata(io_ifu_axi_rdata), .io_ifu_axi_rresp(io_ifu_axi_rresp),
      .io_ifu_axi_rready(io_ifu_axi_rready),
      .io_fill_wr_en(io_fill_wr_en), .io_fill_wr_beat(io_fill_wr_beat),
      .io_fill_wr_data(io_fill_wr_data), .io_fill_wr_err(io_fill_wr_err),
      .io_crit_valid(io_crit_valid), .io_crit_data(io_crit_data), .io_crit_err(io_crit_err),
      .io_fill_done(io_fill_done), .io_fill_err(io_fill_err),
      .io_pmu_bus_trxn(io_pmu_bus_trxn), .io_pmu_bus_busy(io_pmu_bus_busy),
      .io_pmu_bus_error(io_pmu_bus_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1-2 time units after posedge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_miss(input logic [30:0] a, input logic uc);
      io_miss_req = 1'b1;
      io_miss_addr = a;
      io_miss_uncacheable = uc;
      #1;
      chk("miss_ready_idle", io_miss_ready, 1'b1);
      tick();
      io_miss_req = 1'b0;
   endtask

   // Expect n back-to-back ARs (arready=1) in wrap order from crit.
   task automatic issue_ars(input int n, input logic [2:0] crit, input logic [31:0] base);
      logic [2:0] b;
      for (int i = 0; i < n; i++) begin
         b = crit + 3'(i);
         #1;
         chk("arvalid", io_ifu_axi_arvalid, 1'b1);
         chk("arid", io_ifu_axi_arid, b);
         chk("araddr", io_ifu_axi_araddr, base | {26'd0, b, 3'b000});
         chk("pmu_trxn", io_pmu_bus_trxn, 1'b1);
         tick();
      end
   endtask

   task automatic beat(input logic [2:0] rid, input logic [1:0] resp, input logic en,
                       input logic exp_wr, input logic exp_crit);
      logic [63:0] d;
      d = {56'hCAFE_F00D_0000_00, 5'b0, rid};
      io_ifu_bus_clk_en = en;
      io_ifu_axi_rvalid = 1'b1;
      io_ifu_axi_rid    = rid;
      io_ifu_axi_rdata  = d;
      io_ifu_axi_rresp  = resp;
      #1;
      chk("fill_wr_en", io_fill_wr_en, exp_wr);
      chk("fill_wr_beat", io_fill_wr_beat, exp_wr ? rid : 3'd0);
      chk("fill_wr_data", io_fill_wr_data, exp_wr ? d : 64'd0);
      chk("fill_wr_err", io_fill_wr_err, exp_wr & (resp != 2'd0));
      chk("crit_valid", io_crit_valid, exp_crit);
      chk("crit_data", io_crit_data, exp_crit ? d : 64'd0);
      chk("crit_err", io_crit_err, exp_crit & (resp != 2'd0));
      chk("pmu_error", io_pmu_bus_error, en & (resp != 2'd0));
      tick();
      io_ifu_axi_rvalid = 1'b0;
      io_ifu_axi_rresp  = 2'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] r;
      logic [1:0] rs;
      int fired;
      reset = 1'b1;
      io_ifu_bus_clk_en = 1'b1;
      io_exu_flush_final = 1'b0;
      io_miss_req = 1'b0;
      io_miss_addr = '0;
      io_miss_uncacheable = 1'b0;
      io_ifu_axi_arready = 1'b1;
      io_ifu_axi_rvalid = 1'b0;
      io_ifu_axi_rid = '0;
      io_ifu_axi_rdata = '0;
      io_ifu_axi_rresp = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      // reset state
      chk("rst_miss_ready", io_miss_ready, 1'b1);
      chk("rst_rready", io_ifu_axi_rready, 1'b1);
      chk("rst_arvalid", io_ifu_axi_arvalid, 1'b0);
      chk("rst_fill_done", io_fill_done, 1'b0);
      chk("rst_arsize", io_ifu_axi_arsize, 3'h3);
      chk("rst_arlen", io_ifu_axi_arlen, 8'h0);
      chk("rst_arburst", io_ifu_axi_arburst, 2'h1);
      tick();

      // 1: cacheable miss at byte 0x28, in-order responses
      start_miss(31'h0000_0014, 1'b0);
      issue_ars(8, 3'd5, 32'h0);
      chk("t1_arvalid_off", io_ifu_axi_arvalid, 1'b0);
      for (int i = 0; i < 8; i++) begin
         r = 3'd5 + 3'(i);
         beat(r, 2'd0, 1'b1, 1'b1, r == 3'd5);
      end
      chk("t1_done", io_fill_done, 1'b1);
      chk("t1_err", io_fill_err, 1'b0);
      tick();
      chk("t1_ready", io_miss_ready, 1'b1);
      chk("t1_done_off", io_fill_done, 1'b0);

      // 2: reverse-order responses
      start_miss(31'h0000_0014, 1'b0);
      issue_ars(8, 3'd5, 32'h0);
      for (int i = 0; i < 8; i++) begin
         r = 3'd4 - 3'(i);
         beat(r, 2'd0, 1'b1, 1'b1, r == 3'd5);
      end
      chk("t2_done", io_fill_done, 1'b1);
      chk("t2_err", io_fill_err, 1'b0);
      tick();

      // 3: uncacheable, byte addr 0x0080_0072 -> beat 6
      start_miss(31'h0040_0039, 1'b1);
      issue_ars(1, 3'd6, 32'h0080_0040);
      chk("t3_single_ar", io_ifu_axi_arvalid, 1'b0);
      beat(3'd6, 2'd0, 1'b1, 1'b0, 1'b1);
      chk("t3_done", io_fill_done, 1'b1);
      tick();
      chk("t3_ready", io_miss_ready, 1'b1);

      // 4: AR stalled 3 cycles, then flush; AR completes, DRAIN swallows R
      io_ifu_axi_arready = 1'b0;
      start_miss(31'h0000_0014, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_arvalid", io_ifu_axi_arvalid, 1'b1);
         chk("t4_arid", io_ifu_axi_arid, 3'd5);
         chk("t4_araddr", io_ifu_axi_araddr, 32'h28);
         chk("t4_busy", io_pmu_bus_busy, 1'b1);
         tick();
      end
      io_exu_flush_final = 1'b1;
      #1;
      chk("t4_arvalid_flush", io_ifu_axi_arvalid, 1'b1);
      chk("t4_done_flush", io_fill_done, 1'b0);
      tick();
      io_exu_flush_final = 1'b0;
      io_ifu_axi_arready = 1'b1;
      #1;
      chk("t4_arvalid_drain", io_ifu_axi_arvalid, 1'b1);
      chk("t4_arid_drain", io_ifu_axi_arid, 3'd5);
      chk("t4_araddr_drain", io_ifu_axi_araddr, 32'h28);
      chk("t4_trxn_drain", io_pmu_bus_trxn, 1'b1);
      tick();
      chk("t4_arvalid_off", io_ifu_axi_arvalid, 1'b0);
      beat(3'd5, 2'd0, 1'b1, 1'b0, 1'b0);
      chk("t4_no_done", io_fill_done, 1'b0);
      chk("t4_draining", io_miss_ready, 1'b0);
      tick();
      chk("t4_idle", io_miss_ready, 1'b1);
      chk("t4_no_done2", io_fill_done, 1'b0);
      // flush with same-cycle request in IDLE: dropped
      io_miss_req = 1'b1;
      io_exu_flush_final = 1'b1;
      tick();
      io_miss_req = 1'b0;
      io_exu_flush_final = 1'b0;
      #1;
      chk("t4_drop_ready", io_miss_ready, 1'b1);
      chk("t4_drop_arvalid", io_ifu_axi_arvalid, 1'b0);
      tick();

      // 5: bus_clk_en toggling, RRESP=2 on beat 3
      start_miss(31'h0000_0014, 1'b0);
      fired = 0;
      io_ifu_bus_clk_en = 1'b0;
      while (fired < 8) begin
         r = 3'd5 + 3'(fired);
         #1;
         chk("t5_arid", io_ifu_axi_arid, r);
         chk("t5_trxn", io_pmu_bus_trxn, io_ifu_bus_clk_en);
         tick();
         if (io_ifu_bus_clk_en) fired++;
         io_ifu_bus_clk_en = ~io_ifu_bus_clk_en;
      end
      chk("t5_arvalid_off", io_ifu_axi_arvalid, 1'b0);
      for (int i = 0; i < 8; i++) begin
         r  = 3'd5 + 3'(i);
         rs = (r == 3'd3) ? 2'd2 : 2'd0;
         beat(r, rs, 1'b0, 1'b0, 1'b0);
         beat(r, rs, 1'b1, 1'b1, r == 3'd5);
      end
      io_ifu_bus_clk_en = 1'b0;
      #1;
      chk("t5_done", io_fill_done, 1'b1);
      chk("t5_err", io_fill_err, 1'b1);
      tick();
      chk("t5_ready", io_miss_ready, 1'b1);
      io_ifu_bus_clk_en = 1'b1;

      // 6: reset in the middle of WAIT
      start_miss(31'h0000_0014, 1'b0);
      issue_ars(8, 3'd5, 32'h0);
      beat(3'd5, 2'd0, 1'b1, 1'b1, 1'b1);
      beat(3'd6, 2'd0, 1'b1, 1'b1, 1'b0);
      chk("t6_in_wait", io_miss_ready, 1'b0);
      io_ifu_axi_rvalid = 1'b1;
      io_ifu_axi_rid = 3'd7;
      io_ifu_axi_rresp = 2'd2;
      reset = 1'b1;
      #1;
      chk("t6_ready", io_miss_ready, 1'b1);
      chk("t6_arvalid", io_ifu_axi_arvalid, 1'b0);
      chk("t6_wr_en", io_fill_wr_en, 1'b0);
      chk("t6_crit", io_crit_valid, 1'b0);
      chk("t6_pmu_err", io_pmu_bus_error, 1'b0);
      chk("t6_done", io_fill_done, 1'b0);
      tick();
      reset = 1'b0;
      io_ifu_axi_rvalid = 1'b0;
      io_ifu_axi_rresp = 2'd0;
      #1;
      chk("t6_ready_after", io_miss_ready, 1'b1);
      chk("t6_rready_after", io_ifu_axi_rready, 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
